tinymem_mp: RTL and testbench

Parametrised multi-port successor of the single-channel tiny memory interface: an on-chip word-organised RAM serving NPORTS independent requesters (e.g. fetch, load/store, debug) through valid/ready request channels and one-cycle-later response channels. Adds arbitration, flow control, byte/half/word lanes with alignment and range checking, and an error response. Sits between the core's memory stages and local RAM.

---
 rtl/tinymem_mp.sv | 235 +++++++++++++++++++++++
 tb/tb_tinymem_mp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tinymem_mp.sv
// tinymem_mp: multi-port on-chip word RAM with valid/ready request channels
// and single-cycle response pulses.
//
// Parameters:
//   NPORTS      number of requester ports (1..8)
//   DEPTH_WORDS RAM depth in 32-bit words (power of two)
//   BASE_ADDR   byte address of word 0 (aligned to DEPTH_WORDS*4)
//
// Ports (per-port signals are unpacked arrays [NPORTS]):
//   clk_i        clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   req_valid_i  request present
//   req_ready_o  request accepted this cycle (at most one port high)
//   req_addr_i   byte address
//   req_size_i   access size (BYTE/HALF/WORD)
//   req_wr_i     1 = write, 0 = read
//   req_wdata_i  write data, right-aligned
//   rsp_valid_o  response pulse, one cycle after acceptance
//   rsp_rdata_o  read data, right-aligned, zero-extended (0 for writes/errors)
//   rsp_err_o    misaligned or out-of-range access
//
// Build option:
//   TINYMEM_MP_FIXED_PRIO_EN  lowest-index valid port always wins
//                             (default: round-robin arbitration)

package tinymem_mp_pkg;
   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_access_size_t;
endpackage

module tinymem_mp
   import tinymem_mp_pkg::*;
#(
   parameter int unsigned NPORTS      = 2,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             req_valid_i [NPORTS],
   output logic             req_ready_o [NPORTS],
   input  logic [31:0]      req_addr_i  [NPORTS],
   input  mem_access_size_t req_size_i  [NPORTS],
   input  logic             req_wr_i    [NPORTS],
   input  logic [31:0]      req_wdata_i [NPORTS],
   output logic             rsp_valid_o [NPORTS],
   output logic [31:0]      rsp_rdata_o [NPORTS],
   output logic             rsp_err_o   [NPORTS]
);

   localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [PW-1:0] grant_idx;
   logic          grant_any;
   logic          xfer;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
`ifdef TINYMEM_MP_FIXED_PRIO_EN
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
         if (!grant_any && req_valid_i[i]) begin
            grant_any = 1'b1;
            grant_idx = PW'(i);
         end
      end
   end
`else
   logic [PW-1:0] last_grant;

   // Search starts one past the last granted port and wraps modulo NPORTS.
   always_comb begin
      logic [PW-1:0] cand;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
         cand = PW'((32'(last_grant) + 32'd1 + i) % NPORTS);
         if (!grant_any && req_valid_i[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_grant <= PW'(NPORTS - 1);
      end else if (xfer) begin
         last_grant <= grant_idx;
      end
   end
`endif

   // Ready is forced low while reset is held so nothing is accepted.
   assign xfer = grant_any && reset_n_i;

   always_comb begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
         req_ready_o[p] = xfer && (grant_idx == PW'(p));
      end
   end

   // ---------------------------------------------------------------------
   // Selected request decode
   // ---------------------------------------------------------------------
   logic [31:0]      sel_addr;
   logic [31:0]      sel_wdata;
   mem_access_size_t sel_size;
   logic             sel_wr;
   logic [31:0]      offset;
   logic             out_of_range;
   logic             misaligned;
   logic             legal;
   logic [AW-1:0]    word_idx;
   logic [3:0]       be;
   logic [31:0]      wdata_rep;

   assign sel_addr  = req_addr_i[grant_idx];
   assign sel_wdata = req_wdata_i[grant_idx];
   assign sel_size  = req_size_i[grant_idx];
   assign sel_wr    = req_wr_i[grant_idx];

   // BASE_ADDR is word aligned, so offset[1:0] equals the address lane bits.
   assign offset       = sel_addr - BASE_ADDR;
   assign out_of_range = (sel_addr < BASE_ADDR) || ({2'b00, offset[31:2]} >= DEPTH_WORDS);
   assign word_idx     = offset[AW+1:2];
   assign legal        = !out_of_range && !misaligned;

   always_comb begin
      misaligned = 1'b0;
      be         = 4'b0000;
      wdata_rep  = sel_wdata;
      case (sel_size)
         MEM_BYTE: begin
            be        = 4'b0001 << offset[1:0];
            wdata_rep = {4{sel_wdata[7:0]}};
         end
         MEM_HALF: begin
            misaligned = offset[0];
            be         = offset[1] ? 4'b1100 : 4'b0011;
            wdata_rep  = {2{sel_wdata[15:0]}};
         end
         MEM_WORD: begin
            misaligned = (offset[1:0] != 2'b00);
            be         = 4'b1111;
         end
         default: begin
            // Unused size encoding is rejected like a misaligned access.
            misaligned = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Storage (contents are not reset)
   // ---------------------------------------------------------------------
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rsp_word;

   always_ff @(posedge clk_i) begin
      if (xfer && legal && sel_wr) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
         end
      end
   end

   // Raw word is registered at acceptance; lane extraction happens in the
   // response cycle from the registered lane/size info.
   always_ff @(posedge clk_i) begin
      if (xfer && legal && !sel_wr) begin
         rsp_word <= mem[word_idx];
      end
   end

   // ---------------------------------------------------------------------
   // Response
   // ---------------------------------------------------------------------
   logic             rsp_pend;
   logic [PW-1:0]    rsp_port;
   logic             rsp_err;
   logic             rsp_rd;
   logic [1:0]       rsp_shift;
   mem_access_size_t rsp_size;
   logic [31:0]      shifted;
   logic [31:0]      rdata_fmt;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rsp_pend  <= 1'b0;
         rsp_port  <= '0;
         rsp_err   <= 1'b0;
         rsp_rd    <= 1'b0;
         rsp_shift <= '0;
         rsp_size  <= MEM_BYTE;
      end else begin
         rsp_pend <= xfer;
         if (xfer) begin
            rsp_port  <= grant_idx;
            rsp_err   <= !legal;
            rsp_rd    <= legal && !sel_wr;
            rsp_shift <= offset[1:0];
            rsp_size  <= sel_size;
         end
      end
   end

   always_comb begin
      shifted = rsp_word >> {rsp_shift, 3'b000};
      case (rsp_size)
         MEM_BYTE: rdata_fmt = {24'h0, shifted[7:0]};
         MEM_HALF: rdata_fmt = {16'h0, shifted[15:0]};
         default:  rdata_fmt = shifted;
      endcase
   end

   always_comb begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
         rsp_valid_o[p] = rsp_pend && (rsp_port == PW'(p));
         rsp_err_o[p]   = rsp_valid_o[p] && rsp_err;
         rsp_rdata_o[p] = (rsp_valid_o[p] && rsp_rd) ? rdata_fmt : '0;
      end
   end

endmodule

// File: tb/tb_tinymem_mp.sv
// Directed self-checking bench for tinymem_mp (3 ports, 1024 words, base 0).
// Honours TINYMEM_MP_FIXED_PRIO_EN for the arbitration expectations.
module tb_tinymem_mp;
   import tinymem_mp_pkg::*;

   localparam int unsigned NP = 3;
   localparam int unsigned DW = 1024;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid [NP];
   logic             req_ready [NP];
   logic [31:0]      req_addr  [NP];
   mem_access_size_t req_size  [NP];
   logic             req_wr    [NP];
   logic [31:0]      req_wdata [NP];
   logic             rsp_valid [NP];
   logic [31:0]      rsp_rdata [NP];
   logic             rsp_err   [NP];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   tinymem_mp #(
      .NPORTS      (NP),
      .DEPTH_WORDS (DW),
      .BASE_ADDR   (32'h0000_0000)
   ) dut (
      .clk_i       (clk),
      .reset_n_i   (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_addr_i  (req_addr),
      .req_size_i  (req_size),
      .req_wr_i    (req_wr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [NP-1:0] ready_vec();
      logic [NP-1:0] v;
      for (int i = 0; i < NP; i++) v[i] = req_ready[i];
      return v;
   endfunction

   function automatic logic [NP-1:0] rsp_vec();
      logic [NP-1:0] v;
      for (int i = 0; i < NP; i++) v[i] = rsp_valid[i];
      return v;
   endfunction

   // One transfer on port p; checks acceptance, response one cycle later,
   // and that the response pulse lasts exactly one cycle.
   task automatic access(input string tag, input int p, input logic [31:0] addr,
                         input mem_access_size_t size, input logic wr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
      int cyc;
      @(posedge clk); #1;
      req_valid[p] = 1'b1;
      req_addr[p]  = addr;
      req_size[p]  = size;
      req_wr[p]    = wr;
      req_wdata[p] = wdata;
      cyc = 0;
      @(negedge clk);
      while (!req_ready[p] && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, ".ready"}, 32'(req_ready[p]), 32'd1);
      @(posedge clk); #1;
      req_valid[p] = 1'b0;
      check({tag, ".rsp_valid"}, 32'(rsp_valid[p]), 32'd1);
      check({tag, ".rdata"}, rsp_rdata[p], exp_rdata);
      check({tag, ".err"}, 32'(rsp_err[p]), 32'(exp_err));
      @(posedge clk); #1;
      check({tag, ".rsp_drop"}, 32'(rsp_valid[p]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_grant [6];
      for (int i = 0; i < NP; i++) begin
         req_valid[i] = 1'b0;
         req_addr[i]  = '0;
         req_size[i]  = MEM_WORD;
         req_wr[i]    = 1'b0;
         req_wdata[i] = '0;
      end
      for (int k = 0; k < 6; k++) begin
`ifdef TINYMEM_MP_FIXED_PRIO_EN
         exp_grant[k] = 0;
`else
         exp_grant[k] = k % NP;
`endif
      end

      // Reset state, ready must stay low even with a valid request.
      req_valid[0] = 1'b1;
      #12;
      check("reset.ready", 32'(ready_vec()), 32'd0);
      check("reset.rsp_valid", 32'(rsp_vec()), 32'd0);
      check("reset.rdata0", rsp_rdata[0], 32'd0);
      check("reset.err0", 32'(rsp_err[0]), 32'd0);
      req_valid[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Word write then half read of upper half.
      access("wr_word_10", 0, 32'h10, MEM_WORD, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
      access("rd_half_12", 0, 32'h12, MEM_HALF, 1'b0, 32'h0, 32'h0000_DEAD, 1'b0);
      access("rd_half_10", 0, 32'h10, MEM_HALF, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0);

      // Byte lane write merges into an existing word.
      access("wr_word_10b", 0, 32'h10, MEM_WORD, 1'b1, 32'h1122_3344, 32'h0, 1'b0);
      access("wr_byte_11", 0, 32'h11, MEM_BYTE, 1'b1, 32'h0000_00AA, 32'h0, 1'b0);
      access("rd_word_10", 0, 32'h10, MEM_WORD, 1'b0, 32'h0, 32'h1122_AA44, 1'b0);
      access("rd_byte_13", 0, 32'h13, MEM_BYTE, 1'b0, 32'h0, 32'h0000_0011, 1'b0);

      // Misaligned accesses are rejected and leave RAM untouched.
      access("wr_word_00", 0, 32'h00, MEM_WORD, 1'b1, 32'h5566_7788, 32'h0, 1'b0);
      access("rd_word_06", 0, 32'h06, MEM_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
      access("wr_half_03", 0, 32'h03, MEM_HALF, 1'b1, 32'h0000_BEEF, 32'h0, 1'b1);
      access("rd_word_00", 0, 32'h00, MEM_WORD, 1'b0, 32'h0, 32'h5566_7788, 1'b0);
      access("wr_half_02", 0, 32'h02, MEM_HALF, 1'b1, 32'h0000_1234, 32'h0, 1'b0);
      access("rd_word_00b", 0, 32'h00, MEM_WORD, 1'b0, 32'h0, 32'h1234_7788, 1'b0);

      // Range boundary: last word legal, one past it is an error.
      access("wr_last", 2, 32'hFFC, MEM_WORD, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0);
      access("rd_last", 2, 32'hFFC, MEM_WORD, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
      access("rd_oor", 2, 32'h1000, MEM_WORD, 1'b0, 32'h0, 32'h0, 1'b1);
      access("wr_oor", 2, 32'h1000, MEM_WORD, 1'b1, 32'h0BAD_0BAD, 32'h0, 1'b1);
      access("rd_last_b", 2, 32'hFFC, MEM_WORD, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);

      // Back-to-back write then read of the same word on port 1.
      @(posedge clk); #1;
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h20;
      req_size[1]  = MEM_WORD;
      req_wr[1]    = 1'b1;
      req_wdata[1] = 32'h0BAD_F00D;
      @(negedge clk);
      check("raw.wr_ready", 32'(req_ready[1]), 32'd1);
      @(posedge clk); #1;
      req_wr[1] = 1'b0;
      check("raw.wr_rsp", 32'(rsp_valid[1]), 32'd1);
      @(negedge clk);
      check("raw.rd_ready", 32'(req_ready[1]), 32'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      check("raw.rd_rsp", 32'(rsp_valid[1]), 32'd1);
      check("raw.rd_data", rsp_rdata[1], 32'h0BAD_F00D);

      // Reset asserted right after an accept drops the pending response.
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h10;
      req_size[0]  = MEM_WORD;
      req_wr[0]    = 1'b0;
      @(negedge clk);
      check("rst.pre_ready", 32'(req_ready[0]), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      for (int i = 0; i < NP; i++) begin
         req_valid[i] = 1'b1;
         req_addr[i]  = 32'h10;
         req_size[i]  = MEM_WORD;
         req_wr[i]    = 1'b0;
      end
      #1;
      check("rst.rsp_valid", 32'(rsp_vec()), 32'd0);
      check("rst.rdata0", rsp_rdata[0], 32'd0);
      check("rst.err0", 32'(rsp_err[0]), 32'd0);
      check("rst.ready", 32'(ready_vec()), 32'd0);
      @(posedge clk); #1;
      check("rst.rsp_hold", 32'(rsp_vec()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // All ports valid: grant sequence and per-port response routing.
      for (int k = 0; k < 6; k++) begin
         #1;
         check($sformatf("arb.grant%0d", k), 32'(ready_vec()), 32'(1) << exp_grant[k]);
         if (k == 0) begin
            check("arb.no_rsp", 32'(rsp_vec()), 32'd0);
         end else begin
            check($sformatf("arb.rsp%0d", k), 32'(rsp_vec()), 32'(1) << exp_grant[k-1]);
            check($sformatf("arb.rdata%0d", k), rsp_rdata[exp_grant[k-1]], 32'h1122_AA44);
         end
         @(negedge clk);
      end
      #1;
      check("arb.rsp_last", 32'(rsp_vec()), 32'(1) << exp_grant[5]);
      for (int i = 0; i < NP; i++) req_valid[i] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle.rsp", 32'(rsp_vec()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
